// File: rtl/mult_issue_arbiter.sv
// Round-robin arbiter sharing one 33x33 multiplier between the integer EX pipe and
// the FP unit, with a LAT-deep result pipeline. Define MULT_ARB_STATS_EN for grant counters.
module mult_issue_arbiter #(
  parameter int unsigned TAG_W     = 5,
  parameter int unsigned LAT       = 2,
  parameter logic [4:0]  ALU_FMULS = 5'h1C
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             int_req,
  input  logic [31:0]      int_opa,
  input  logic [31:0]      int_opb,
  input  logic [4:0]       int_func,
  input  logic [TAG_W-1:0] int_tag,
  output logic             int_gnt,
  input  logic             fp_req,
  input  logic [31:0]      fp_opa,
  input  logic [31:0]      fp_opb,
  input  logic [TAG_W-1:0] fp_tag,
  output logic             fp_gnt,
  output logic [31:0]      mul_opa,
  output logic [31:0]      mul_opb,
  output logic [4:0]       mul_func,
  input  logic [65:0]      mul_result,
  output logic             res_valid,
  output logic             res_src,
  output logic [TAG_W-1:0] res_tag,
  output logic [65:0]      res_data,
  input  logic             res_ready,
  output logic [31:0]      stat_int_gnt,
  output logic [31:0]      stat_fp_gnt,
  output logic [31:0]      stat_conflict
);

  localparam int unsigned DATA_W = 66;
  localparam int unsigned LAST   = LAT - 1;

  logic [LAT-1:0]    vld_q;
  logic              src_q  [LAT];
  logic [TAG_W-1:0]  tag_q  [LAT];
  logic [DATA_W-1:0] data_q [LAT];
  logic              rr_last;  // 1 = FP won last, so integer wins the next conflict
  logic              stall;
  logic              issue;
  logic [TAG_W-1:0]  issue_tag;

  assign stall = vld_q[LAST] & ~res_ready;
  assign issue = int_gnt | fp_gnt;

  // Grant and multiplier operand steering
  always_comb begin
    int_gnt   = 1'b0;
    fp_gnt    = 1'b0;
    mul_opa   = '0;
    mul_opb   = '0;
    mul_func  = '0;
    issue_tag = '0;
    if (!stall) begin
      if (int_req && (!fp_req || rr_last)) begin
        int_gnt = 1'b1;
      end else if (fp_req) begin
        fp_gnt = 1'b1;
      end
    end
    if (int_gnt) begin
      mul_opa   = int_opa;
      mul_opb   = int_opb;
      mul_func  = int_func;
      issue_tag = int_tag;
    end else if (fp_gnt) begin
      mul_opa   = fp_opa;
      mul_opb   = fp_opb;
      mul_func  = ALU_FMULS;
      issue_tag = fp_tag;
    end
  end

  // Result pipeline; the whole pipe freezes while the output is stalled
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vld_q   <= '0;
      rr_last <= 1'b1;
      for (int unsigned i = 0; i < LAT; i++) begin
        src_q[i]  <= 1'b0;
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else if (!stall) begin
      vld_q[0]  <= issue;
      src_q[0]  <= fp_gnt;
      tag_q[0]  <= issue_tag;
      data_q[0] <= issue ? mul_result : '0;
      for (int unsigned i = 1; i < LAT; i++) begin
        vld_q[i]  <= vld_q[i-1];
        src_q[i]  <= src_q[i-1];
        tag_q[i]  <= tag_q[i-1];
        data_q[i] <= data_q[i-1];
      end
      if (issue) rr_last <= fp_gnt;
    end
  end

  assign res_valid = vld_q[LAST];
  assign res_src   = src_q[LAST];
  assign res_tag   = tag_q[LAST];
  assign res_data  = data_q[LAST];

`ifdef MULT_ARB_STATS_EN
  // Saturating grant / conflict counters
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stat_int_gnt  <= '0;
      stat_fp_gnt   <= '0;
      stat_conflict <= '0;
    end else begin
      if (int_gnt && (stat_int_gnt != '1)) stat_int_gnt <= stat_int_gnt + 32'd1;
      if (fp_gnt && (stat_fp_gnt != '1)) stat_fp_gnt <= stat_fp_gnt + 32'd1;
      if (int_req && fp_req && !stall && (stat_conflict != '1))
        stat_conflict <= stat_conflict + 32'd1;
    end
  end
`else
  assign stat_int_gnt  = '0;
  assign stat_fp_gnt   = '0;
  assign stat_conflict = '0;
`endif

endmodule

// File: tb/tb_mult_issue_arbiter.sv
// Randomized self-checking bench for mult_issue_arbiter against an in-order
// scoreboard model of arbitration, latency and stall behaviour.
module tb_mult_issue_arbiter;

  localparam int unsigned TAG_W = 5;
  localparam int unsigned LAT   = 2;
  localparam logic [4:0] F_MUL    = 5'h08;
  localparam logic [4:0] F_MULH   = 5'h09;
  localparam logic [4:0] F_MULHSU = 5'h0A;
  localparam logic [4:0] F_MULHU  = 5'h0B;
  localparam logic [4:0] F_FMULS  = 5'h1C;

  logic             clock = 1'b0;
  logic             reset_n;
  logic             int_req, fp_req, int_gnt, fp_gnt;
  logic [31:0]      int_opa, int_opb, fp_opa, fp_opb, mul_opa, mul_opb;
  logic [4:0]       int_func, mul_func;
  logic [TAG_W-1:0] int_tag, fp_tag, res_tag;
  logic [65:0]      mul_result, res_data;
  logic             res_valid, res_src, res_ready;
  logic [31:0]      stat_int_gnt, stat_fp_gnt, stat_conflict;

  mult_issue_arbiter #(.TAG_W(TAG_W), .LAT(LAT), .ALU_FMULS(F_FMULS)) dut (
    .clock(clock), .reset_n(reset_n),
    .int_req(int_req), .int_opa(int_opa), .int_opb(int_opb), .int_func(int_func),
    .int_tag(int_tag), .int_gnt(int_gnt),
    .fp_req(fp_req), .fp_opa(fp_opa), .fp_opb(fp_opb), .fp_tag(fp_tag), .fp_gnt(fp_gnt),
    .mul_opa(mul_opa), .mul_opb(mul_opb), .mul_func(mul_func), .mul_result(mul_result),
    .res_valid(res_valid), .res_src(res_src), .res_tag(res_tag), .res_data(res_data),
    .res_ready(res_ready),
    .stat_int_gnt(stat_int_gnt), .stat_fp_gnt(stat_fp_gnt), .stat_conflict(stat_conflict)
  );

  always #5 clock = ~clock;

  // Behavioural 33x33 multiplier; FMULS multiplies the two 24-bit significands
  function automatic logic [65:0] mult_model(input logic [31:0] a, input logic [31:0] b,
                                             input logic [4:0] f);
    logic signed [65:0] ae, be;
    case (f)
      F_MULHU:  begin ae = $signed({34'd0, a}); be = $signed({34'd0, b}); end
      F_MULHSU: begin ae = $signed({{34{a[31]}}, a}); be = $signed({34'd0, b}); end
      F_FMULS:  begin ae = $signed({42'd0, 1'b1, a[22:0]}); be = $signed({42'd0, 1'b1, b[22:0]}); end
      default:  begin ae = $signed({{34{a[31]}}, a}); be = $signed({{34{b[31]}}, b}); end
    endcase
    return 66'(ae * be);
  endfunction

  always_comb mul_result = mult_model(mul_opa, mul_opb, mul_func);

  typedef struct {
    logic             src;
    logic [TAG_W-1:0] tag;
    logic [65:0]      data;
    int unsigned      cnt;
  } ent_t;

  ent_t        q[$];
  logic        pref_int;
  int unsigned m_int, m_fp, m_conf;
  int          errors = 0;
  int          checks = 0;
  logic        s_int_gnt, s_fp_gnt, s_res_valid, s_res_src;
  logic [TAG_W-1:0] s_res_tag;
  logic [65:0] s_res_data;

  task automatic check(input string tag, input logic [65:0] got, input logic [65:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    q.delete();
    pref_int = 1'b1;
    m_int = 0; m_fp = 0; m_conf = 0;
  endfunction

  // One clock: check at negedge, advance the model at posedge, return 1 unit later
  task automatic tick();
    logic vis, stl, eg_int, eg_fp;
    logic [31:0] e_opa;
    logic [4:0]  e_func;
    ent_t e;
    @(negedge clock);
    vis    = (q.size() > 0) && (q[0].cnt == LAT);
    stl    = vis && !res_ready;
    eg_int = !stl && int_req && (!fp_req || pref_int);
    eg_fp  = !stl && fp_req && (!int_req || !pref_int);
    check("int_gnt", 66'(int_gnt), 66'(eg_int));
    check("fp_gnt", 66'(fp_gnt), 66'(eg_fp));
    check("res_valid", 66'(res_valid), 66'(vis));
    if (vis) begin
      check("res_src", 66'(res_src), 66'(q[0].src));
      check("res_tag", 66'(res_tag), 66'(q[0].tag));
      check("res_data", res_data, q[0].data);
    end
    e_opa  = eg_int ? int_opa : (eg_fp ? fp_opa : 32'd0);
    e_func = eg_int ? int_func : (eg_fp ? F_FMULS : 5'd0);
    check("mul_opa", 66'(mul_opa), 66'(e_opa));
    check("mul_func", 66'(mul_func), 66'(e_func));
`ifdef MULT_ARB_STATS_EN
    check("stat_int", 66'(stat_int_gnt), 66'(m_int));
    check("stat_fp", 66'(stat_fp_gnt), 66'(m_fp));
    check("stat_conf", 66'(stat_conflict), 66'(m_conf));
`else
    check("stat_tied", 66'(stat_int_gnt | stat_fp_gnt | stat_conflict), 66'd0);
`endif
    s_int_gnt = int_gnt; s_fp_gnt = fp_gnt; s_res_valid = res_valid;
    s_res_src = res_src; s_res_tag = res_tag; s_res_data = res_data;
    e.src  = eg_fp;
    e.tag  = eg_int ? int_tag : fp_tag;
    e.data = eg_int ? mult_model(int_opa, int_opb, int_func) : mult_model(fp_opa, fp_opb, F_FMULS);
    e.cnt  = 1;
    @(posedge clock);
    if (!stl) begin
      if (vis && res_ready) void'(q.pop_front());
      foreach (q[i]) q[i].cnt++;
      if (eg_int || eg_fp) q.push_back(e);
    end
    if (eg_int) m_int++;
    if (eg_fp) m_fp++;
    if (int_req && fp_req && !stl) m_conf++;
    if (eg_int || eg_fp) pref_int = eg_fp;
    #1;
  endtask

  function automatic logic [4:0] rand_func();
    case ($urandom_range(3))
      0: return F_MUL;
      1: return F_MULH;
      2: return F_MULHSU;
      default: return F_MULHU;
    endcase
  endfunction

  initial begin
    logic [65:0] hold;
    reset_n = 1'b0; res_ready = 1'b1;
    int_req = 0; int_opa = 0; int_opb = 0; int_func = 0; int_tag = 0;
    fp_req = 0; fp_opa = 0; fp_opb = 0; fp_tag = 0;
    model_reset();
    #12;
    check("rst_valid", 66'(res_valid), 66'd0);
    check("rst_data", res_data, 66'd0);
    check("rst_tag", 66'({res_src, res_tag}), 66'd0);
    check("rst_gnt", 66'({int_gnt, fp_gnt}), 66'd0);
    #10 reset_n = 1'b1;
    @(posedge clock); #1;

    // MULHU of all-ones, tag 3: result visible LAT cycles after grant
    int_req = 1; int_opa = 32'hFFFFFFFF; int_opb = 32'hFFFFFFFF; int_func = F_MULHU; int_tag = 5'd3;
    tick();
    check("mulhu_gnt", 66'(s_int_gnt), 66'd1);
    int_req = 0;
    tick();
    check("mulhu_n1_valid", 66'(s_res_valid), 66'd0);
    tick();
    check("mulhu_valid", 66'(s_res_valid), 66'd1);
    check("mulhu_src_tag", 66'({s_res_src, s_res_tag}), 66'({1'b0, 5'd3}));
    check("mulhu_data", s_res_data, 66'h0_FFFFFFFE_00000001);

    int_req = 1; int_func = F_MULH; int_tag = 5'd7;
    tick(); int_req = 0; tick(); tick();
    check("mulh_data", s_res_data, 66'h1);

    fp_req = 1; fp_opa = 32'h3F800000; fp_opb = 32'h40000000; fp_tag = 5'd9;
    tick();
    check("fmuls_gnt", 66'(s_fp_gnt), 66'd1);
    fp_req = 0; tick(); tick();
    check("fmuls_data", s_res_data, 66'h0000_4000_0000_0000);
    check("fmuls_src", 66'(s_res_src), 66'd1);

    // Sustained conflict alternates starting with integer
    int_req = 1; fp_req = 1; int_func = F_MUL; int_opa = 32'd5; int_opb = 32'd7; fp_tag = 5'd1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("alt_int", 66'(s_int_gnt), 66'(i % 2 == 0));
      check("alt_fp", 66'(s_fp_gnt), 66'(i % 2 == 1));
    end
    int_req = 0; fp_req = 0;
    tick(); tick(); tick();

    // Back-pressure with a full pipeline, then release
    res_ready = 0; int_req = 1; int_func = F_MULHSU;
    for (int i = 0; i < 3; i++) begin int_tag = 5'(10 + i); tick(); end
    hold = s_res_data;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_gnt", 66'(s_int_gnt), 66'd0);
      check("stall_hold", s_res_data, hold);
    end
    res_ready = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("drain_gnt", 66'(s_int_gnt), 66'd1);
      check("drain_valid", 66'(s_res_valid), 66'd1);
    end
    int_req = 0;
    tick(); tick(); tick();

    // Reset with two ops in flight
    int_req = 1; int_tag = 5'd4; tick(); int_tag = 5'd5; tick();
    int_req = 0;
    check("pre_rst_valid", 66'(res_valid), 66'd1);
    reset_n = 1'b0;
    #1;
    check("async_rst_valid", 66'(res_valid), 66'd0);
    model_reset();
    #10 reset_n = 1'b1;
    @(posedge clock); #1;
    int_req = 1; fp_req = 1;
    tick();
    check("post_rst_int_wins", 66'(s_int_gnt), 66'd1);
    int_req = 0; fp_req = 0;
    tick(); tick();

    // Randomized traffic; requesters hold until granted
    for (int c = 0; c < 400; c++) begin
      res_ready = ($urandom_range(9) < 7);
      tick();
      if (s_int_gnt || !int_req) begin
        int_req = $urandom_range(1); int_opa = $urandom(); int_opb = $urandom();
        int_func = rand_func(); int_tag = 5'($urandom());
      end
      if (s_fp_gnt || !fp_req) begin
        fp_req = $urandom_range(1); fp_opa = $urandom(); fp_opb = $urandom();
        fp_tag = 5'($urandom());
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
